mem_arbiter: RTL
================

# mem_arbiter

N-channel round-robin arbiter that sits between the caches (instruction cache, data cache, and later vector or DMA clients) and the single-port main memory. It generalises the fixed two-way i-cache/d-cache selection to `NUM_CH` requesters. It also adds burst transfers of 1..`VECTOR_SIZE` words per grant, serialising each burst into single-word memory transactions with a valid/ready handshake.

## Interface
Parameters:
- `NUM_CH`, 2: number of requesting channels (≥2); channel 0 is the i-cache by convention.
- `ADDR_WIDTH`, 17: byte address width.
- `LEN`, 32: word width in bits.
- `VECTOR_SIZE`, 8: maximum words per burst.
- `ENTRY_INDEX_SIZE`, 3: log2(`VECTOR_SIZE`); the length field is `ENTRY_INDEX_SIZE+1` bits.

Ports:
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: reset, asynchronous and active-low.
- `ch_vis_signal` in, 2*NUM_CH: per-channel request. 00 IDLE, 01 READ, 10 WRITE, 11 reserved (treated as IDLE).
- `ch_addr` in, ADDR_WIDTH*NUM_CH: per-channel burst start byte address, word-aligned.
- `ch_length` in, (ENTRY_INDEX_SIZE+1)*NUM_CH: per-channel burst length in words.
- `ch_wdata` in, LEN*VECTOR_SIZE*NUM_CH: per-channel write data; word k is at `[k*LEN +: LEN]`.
- `ch_rdata` out, LEN*VECTOR_SIZE: read data, shared by all channels and valid with DONE.
- `ch_status` out, 2*NUM_CH: per-channel status. 00 IDLE, 01 BUSY, 10 DONE.
- `mem_valid` out, 1: word request to memory.
- `mem_write` out, 1: 1 = write, 0 = read.
- `mem_addr` out, ADDR_WIDTH: word byte address.
- `mem_wdata` out, LEN: write word.
- `mem_ready` in, 1: memory accepts the request this cycle.
- `mem_rvalid` in, 1: read word returned this cycle.
- `mem_rdata` in, LEN: returned read word.

## Operation
- FSM states: IDLE, ISSUE, WAIT_R, DONE.
- **IDLE**
  - Sample all channels whose signal is READ or WRITE.
  - Pick the first requester searching from `last_grant+1` upward, wrapping modulo `NUM_CH`.
  - Latch channel id, op, address and effective length; clear the read buffer and the word counter `k`.
  - Granted channel status goes BUSY. Go to ISSUE.
- **Effective length**
  - 0 is treated as 1.
  - Values above `VECTOR_SIZE` clamp to `VECTOR_SIZE`.
- **ISSUE**
  - Drive `mem_valid=1`, `mem_addr=base+4*k`, and `mem_wdata` = latched write word k.
  - On `mem_valid & mem_ready`:
    - Read: go to WAIT_R.
    - Write: if k is the last word go to DONE, otherwise increment k and stay in ISSUE.
  - Without `mem_ready`, hold all outputs unchanged.
- **WAIT_R**
  - `mem_valid=0`.
  - On `mem_rvalid`, store `mem_rdata` into buffer word k.
  - If k is the last word go to DONE, otherwise increment k and go to ISSUE.
- **DONE**
  - Status of the granted channel = DONE for exactly one cycle; `ch_rdata` is valid.
  - Update `last_grant` to the granted id. Go to IDLE.
- Requesters must drop to IDLE or present a new request in the cycle after DONE. IDLE re-arbitrates one cycle after DONE, so a held request is served again as a new transaction.
- Non-granted channels always show IDLE.
- Write data and address are latched at grant. Requester changes during BUSY are ignored.
- `ch_rdata` holds its value until the next grant clears it. Words at or beyond the effective length read as zero.
- `mem_rvalid` outside WAIT_R is ignored.

## Timing
- Reset values (async assert): state IDLE, `last_grant=NUM_CH-1` (channel 0 wins first), all `ch_status`=00, `ch_rdata`=0, `mem_valid=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`.
- Reset asserted mid-burst aborts the burst immediately. No DONE is issued, and a late `mem_rvalid` after reset release is ignored.
- Request-to-DONE latency with always-ready, 1-cycle-read memory:
  - Read: 1 + 2L cycles (grant, then ISSUE + WAIT_R per word), DONE in the following cycle.
  - Write: 1 + L cycles, DONE in the following cycle.
- Simultaneous requests are resolved only in IDLE. A request arriving during BUSY waits; no preemption.
- Starvation bound: a held request is granted within `NUM_CH-1` other bursts.
- Address arithmetic is modulo 2^ADDR_WIDTH; a burst wraps silently at the top of the space.

## Structure
- Shared package holds:
  - `MEM_VIS_IDLE/READ/WRITE` encodings.
  - `MEM_STATUS_IDLE/BUSY/DONE` encodings.
  - FSM state constants.
  - `CH_IDX_W = $clog2(NUM_CH)`.
- One sub-module, `rr_picker`: combinational round-robin priority select, taking `req[NUM_CH-1:0]` and `last_grant` and producing `grant_id` and `grant_valid`.
- Integration: the main memory is reduced to a single word port behind this block.

## Test plan
- Reset: assert `rst=0` mid-write burst -> all outputs zero immediately; after release, a new channel-0 READ at 0x100 completes normally.
- Single read: ch1 READ, addr 0x40, len 1, `mem_rdata=0xDEADBEEF` -> `mem_addr=0x40`; `ch_status[3:2]`=10 at cycle 3; `ch_rdata[31:0]=0xDEADBEEF`, rest zero.
- Vector write: ch1 WRITE, addr 0x80, len 8, ready stalled 2 cycles on word 3 -> eight accepted writes at 0x80..0x9C carrying words 0..7 in order; DONE once.
- Contention: ch0 and ch1 request continuously -> grants alternate 0,1,0,1; with NUM_CH=4 all requesting -> 0,1,2,3,0.
- Length edges: len 0 -> one word transferred; len 15 -> eight words; READ at 0x1FFFC len 2 -> second address 0x00000.
- Held request: ch0 keeps READ after DONE -> IDLE for one cycle, then regranted (if sole requester) with a fresh burst.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the N-channel round-robin memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_VIS_IDLE  = 2'b00,
    MEM_VIS_READ  = 2'b01,
    MEM_VIS_WRITE = 2'b10
  } mem_vis_e;

  typedef enum logic [1:0] {
    MEM_STATUS_IDLE = 2'b00,
    MEM_STATUS_BUSY = 2'b01,
    MEM_STATUS_DONE = 2'b10
  } mem_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_R,
    ST_DONE
  } arb_state_e;

  // Channel-index width; a two-channel arbiter still needs one bit.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned eff_len(input int unsigned raw, input int unsigned max_len);
    if (raw == 0)
      return 1;
    if (raw > max_len)
      return max_len;
    return raw;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requester above last_grant, wrapping.
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CH_IDX_W = 1
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_IDX_W-1:0] last_grant,
  output logic [CH_IDX_W-1:0] grant_id,
  output logic                grant_valid
);

  logic [CH_IDX_W-1:0] w_cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    w_cand      = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      w_cand = CH_IDX_W'((32'(last_grant) + off) % NUM_CH);
      if (!grant_valid && req[w_cand]) begin
        grant_valid = 1'b1;
        grant_id    = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter serialising 1..VECTOR_SIZE word bursts onto a
// single-word valid/ready memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH           = 2,
  parameter int unsigned ADDR_WIDTH       = 17,
  parameter int unsigned LEN              = 32,
  parameter int unsigned VECTOR_SIZE      = 8,
  parameter int unsigned ENTRY_INDEX_SIZE = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [2*NUM_CH-1:0]                         ch_vis_signal,
  input  logic [ADDR_WIDTH*NUM_CH-1:0]                ch_addr,
  input  logic [(ENTRY_INDEX_SIZE+1)*NUM_CH-1:0]      ch_length,
  input  logic [LEN*VECTOR_SIZE*NUM_CH-1:0]           ch_wdata,
  output logic [LEN*VECTOR_SIZE-1:0]                  ch_rdata,
  output logic [2*NUM_CH-1:0]                         ch_status,
  output logic                                        mem_valid,
  output logic                                        mem_write,
  output logic [ADDR_WIDTH-1:0]                       mem_addr,
  output logic [LEN-1:0]                              mem_wdata,
  input  logic                                        mem_ready,
  input  logic                                        mem_rvalid,
  input  logic [LEN-1:0]                              mem_rdata
);

  localparam int unsigned CH_IDX_W = ch_idx_w(NUM_CH);
  localparam int unsigned LW       = ENTRY_INDEX_SIZE + 1;
  localparam int unsigned BW       = LEN * VECTOR_SIZE;

  arb_state_e            r_state, w_state_nxt;
  logic [CH_IDX_W-1:0]   r_last_grant, r_ch_id, w_grant_id;
  logic                  w_grant_valid, r_write, w_last;
  logic [NUM_CH-1:0]     w_req;
  logic [ADDR_WIDTH-1:0] r_base, w_sel_addr, w_addr;
  logic [LW-1:0]         r_len, r_k, w_sel_len, w_eff_len;
  logic [1:0]            w_sel_vis;
  logic [BW-1:0]         r_wdata, r_rdata, w_sel_wdata;
  logic [LEN-1:0]        w_word;

  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      w_req[i] = (ch_vis_signal[2*i +: 2] == MEM_VIS_READ) ||
                 (ch_vis_signal[2*i +: 2] == MEM_VIS_WRITE);
  end

  rr_picker #(
    .NUM_CH   (NUM_CH),
    .CH_IDX_W (CH_IDX_W)
  ) u_rr_picker (
    .req         (w_req),
    .last_grant  (r_last_grant),
    .grant_id    (w_grant_id),
    .grant_valid (w_grant_valid)
  );

  // Constant-index mux loops keep every part-select static.
  always_comb begin
    w_sel_vis   = '0;
    w_sel_addr  = '0;
    w_sel_len   = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_grant_id == CH_IDX_W'(i)) begin
        w_sel_vis   = ch_vis_signal[2*i +: 2];
        w_sel_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len   = ch_length[i*LW +: LW];
        w_sel_wdata = ch_wdata[i*BW +: BW];
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < VECTOR_SIZE; k++)
      if (r_k == LW'(k))
        w_word = r_wdata[k*LEN +: LEN];
  end

  assign w_eff_len = LW'(eff_len(32'(w_sel_len), VECTOR_SIZE));
  assign w_last    = (r_k == r_len - LW'(1));
  assign w_addr    = r_base + ADDR_WIDTH'({r_k, 2'b00});
  assign ch_rdata  = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_valid   = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ch_status   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid)
          w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_valid = 1'b1;
        mem_write = r_write;
        mem_addr  = w_addr;
        mem_wdata = w_word;
        if (mem_ready) begin
          if (!r_write)
            w_state_nxt = ST_WAIT_R;
          else if (w_last)
            w_state_nxt = ST_DONE;
        end
      end
      ST_WAIT_R: begin
        if (mem_rvalid)
          w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_ch_id == CH_IDX_W'(i)) begin
        if (r_state == ST_ISSUE || r_state == ST_WAIT_R)
          ch_status[2*i +: 2] = MEM_STATUS_BUSY;
        else if (r_state == ST_DONE)
          ch_status[2*i +: 2] = MEM_STATUS_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= CH_IDX_W'(NUM_CH - 1);
      r_ch_id      <= '0;
      r_write      <= 1'b0;
      r_base       <= '0;
      r_len        <= '0;
      r_k          <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_ch_id <= w_grant_id;
            r_write <= (w_sel_vis == MEM_VIS_WRITE);
            r_base  <= w_sel_addr;
            r_len   <= w_eff_len;
            r_wdata <= w_sel_wdata;
            r_rdata <= '0;
            r_k     <= '0;
          end
        end
        ST_ISSUE: begin
          if (mem_ready && r_write && !w_last)
            r_k <= r_k + LW'(1);
        end
        ST_WAIT_R: begin
          if (mem_rvalid) begin
            for (int unsigned k = 0; k < VECTOR_SIZE; k++)
              if (r_k == LW'(k))
                r_rdata[k*LEN +: LEN] <= mem_rdata;
            if (!w_last)
              r_k <= r_k + LW'(1);
          end
        end
        ST_DONE:  r_last_grant <= r_ch_id;
        default: ;
      endcase
    end
  end

endmodule
